// File: rtl/cpu_io_port_if.sv
// Bus and stream signals of the CPU I/O port, without the bidirectional data bus.
// The slave modport is the port's own view; master is the CPU/environment side.
interface cpu_io_port_if;
  logic [12:0] addr;
  logic        rd;
  logic        wr;
  logic        io_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  addr, rd, wr, tx_ready, rx_data, rx_valid,
    output io_sel, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, rd, wr, tx_ready, rx_data, rx_valid,
    input  io_sel, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/cpu_io_port.sv
// Memory-mapped I/O port: CPU stores feed a TX FIFO, CPU loads read status or the RX byte.
// Define CPU_IO_PORT_RX_EN to build the RX holding register; otherwise RX is tied off.
module cpu_io_port #(
  parameter logic [12:0] BASE_ADDR = 13'h1000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic         clk,
  input  logic         rst,
  cpu_io_port_if.slave bus,
  inout  wire [7:0]    data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 4;
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  logic [1:0] offset;
  assign bus.io_sel = (bus.addr[12:2] == BASE_ADDR[12:2]);
  assign offset     = bus.addr[1:0];

  // Strobe edge detection; wr_q/rd_q reset high so strobes held through reset are not events
  logic wr_q, rd_q, rd_hit_q;
  logic wr_ev, rd_pop_ev;

  assign wr_ev     = bus.wr & ~wr_q & bus.io_sel;
  assign rd_pop_ev = ~bus.rd & rd_q & rd_hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b1;
      rd_q     <= 1'b1;
      rd_hit_q <= 1'b0;
    end else begin
      wr_q     <= bus.wr;
      rd_q     <= bus.rd;
      rd_hit_q <= bus.rd & bus.io_sel & (offset == 2'd0);
    end
  end

  // TX FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;
  logic          full, empty, push_req, push_ok, tx_pop, flush, clr_drop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_req = wr_ev & (offset == 2'd0);
  assign flush    = wr_ev & (offset == 2'd2) & data[1];
  assign clr_drop = wr_ev & (offset == 2'd2) & data[0];
  assign tx_pop   = ~empty & bus.tx_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok  = push_req & (~full | tx_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = wrap_inc(tail_q);
      if (tx_pop)  head_d = wrap_inc(head_q);
      count_d = count_q + CW'(push_ok) - CW'(tx_pop);
    end
    if (push_req & full & ~tx_pop) drop_d = 1'b1;
    if (clr_drop)                  drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[tail_q] <= data;
  end

  assign bus.tx_data  = mem_q[head_q];
  assign bus.tx_valid = ~empty;

  // RX holding register
  logic [7:0] rx_byte;
  logic       rx_hold;

`ifdef CPU_IO_PORT_RX_EN
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q;
  logic       capture;

  assign capture = bus.rx_valid & ~hold_valid_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    if (capture)        hold_valid_d = 1'b1;
    else if (rd_pop_ev) hold_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_valid_q <= 1'b0;
    else     hold_valid_q <= hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) hold_data_q <= bus.rx_data;
  end

  assign bus.rx_ready = ~hold_valid_q;
  assign rx_byte      = hold_data_q;
  assign rx_hold      = hold_valid_q;
`else
  logic unused_rx;
  assign unused_rx    = ^{bus.rx_data, bus.rx_valid, rd_pop_ev};
  assign bus.rx_ready = 1'b0;
  assign rx_byte      = 8'h00;
  assign rx_hold      = 1'b0;
`endif

  // Read path; STATUS shows registered state only
  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    case (offset)
      2'd0:    rdata = rx_byte;
      2'd1:    rdata = {count_q, drop_q, rx_hold, empty, full};
      default: rdata = 8'h00;
    endcase
  end

  assign data = (bus.rd & bus.io_sel) ? rdata : 8'hzz;

endmodule

// File: tb/tb_cpu_io_port.sv
// Randomized scoreboard bench for cpu_io_port against a queue-based model of the port.
`timescale 1ns/1ps
module tb_cpu_io_port;
  localparam int DEPTH = 8;
  localparam logic [12:0] A_DATA = 13'h1000;
  localparam logic [12:0] A_STAT = 13'h1001;
  localparam logic [12:0] A_CTRL = 13'h1002;
  localparam logic [12:0] A_RSVD = 13'h1003;
  localparam logic [12:0] A_MISS = 13'h0FFC;
`ifdef CPU_IO_PORT_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_io_port_if bus();
  wire  [7:0] data;
  logic [7:0] cpu_dout  = 8'h00;
  logic       cpu_drive = 1'b0;
  assign data = cpu_drive ? cpu_dout : 8'hzz;

  cpu_io_port #(.BASE_ADDR(A_DATA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .data(data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: TX contents as a queue, RX as a valid flag plus byte
  logic [7:0] m_tx[$];
  bit         m_drop = 1'b0;
  bit         m_hold = 1'b0;
  logic [7:0] m_hold_data = 8'h00;
  logic [7:0] rd_exp[$];
  bit         rd_prev = 1'b0;

  function automatic logic [7:0] m_status();
    return {4'(m_tx.size()), m_drop, m_hold, (m_tx.size() == 0), (m_tx.size() == DEPTH)};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Monitor: TX stream and CPU read data, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      check1("tx_valid", bus.tx_valid, m_tx.size() != 0);
      if (bus.tx_valid && bus.tx_ready && m_tx.size() != 0) begin
        check8("tx_data", bus.tx_data, m_tx[0]);
        void'(m_tx.pop_front());
      end
      if (bus.rd && !rd_prev) begin
        if (rd_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_data: got %02h expected no read", data);
        end else begin
          check8("rd_data", data, rd_exp.pop_front());
        end
      end
    end
    rd_prev = bus.rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [7:0] v, input int hold);
    bit hit, will_pop, was_full;
    hit      = (a[12:2] == A_DATA[12:2]);
    bus.addr = a;
    cpu_dout = v;
    cpu_drive = 1'b1;
    bus.wr   = 1'b1;
    will_pop = bus.tx_ready && (m_tx.size() != 0);
    was_full = (m_tx.size() == DEPTH);
    tick();
    check1("io_sel", bus.io_sel, hit);
    if (hit) begin
      case (a[1:0])
        2'd0: if (was_full && !will_pop) m_drop = 1'b1; else m_tx.push_back(v);
        2'd2: begin
          if (v[1]) m_tx.delete();
          if (v[0]) m_drop = 1'b0;
        end
        default: ;
      endcase
    end
    repeat (hold - 1) tick();
    bus.wr    = 1'b0;
    cpu_drive = 1'b0;
    tick();
  endtask

  task automatic cpu_read(input logic [12:0] a, input int hold);
    logic [7:0] e;
    case (a[1:0])
      2'd0:    e = RX_EN ? m_hold_data : 8'h00;
      2'd1:    e = m_status();
      default: e = 8'h00;
    endcase
    rd_exp.push_back(e);
    bus.addr = a;
    bus.rd   = 1'b1;
    repeat (hold) tick();
    bus.rd = 1'b0;
    if (a[1:0] == 2'd0 && m_hold) check1("rx_ready_before_pop", bus.rx_ready, 1'b0);
    tick();
    if (a[1:0] == 2'd0) m_hold = 1'b0;
    check1("rx_ready_after_read", bus.rx_ready, RX_EN && !m_hold);
  endtask

  task automatic rx_send(input logic [7:0] v);
    bus.rx_valid = 1'b1;
    bus.rx_data  = v;
    tick();
    if (RX_EN && !m_hold) begin
      m_hold      = 1'b1;
      m_hold_data = v;
    end
    bus.rx_valid = 1'b0;
    check1("rx_ready_capture", bus.rx_ready, RX_EN && !m_hold);
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (m_tx.size() != 0 && n < max) begin
      tick();
      n++;
    end
    total++;
    if (m_tx.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d bytes left expected 0", m_tx.size());
    end
  endtask

  task automatic do_reset_wr_held();
    rst       = 1'b1;
    bus.addr  = A_DATA;
    cpu_dout  = 8'h77;
    cpu_drive = 1'b1;
    bus.wr    = 1'b1;
    m_tx.delete();
    m_drop = 1'b0;
    m_hold = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    bus.wr    = 1'b0;
    cpu_drive = 1'b0;
    tick();
  endtask

  initial begin
    int op;
    bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.tx_ready = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check1("rx_ready_reset", bus.rx_ready, RX_EN);
    check1("tx_valid_reset", bus.tx_valid, 1'b0);
    bus.addr  = A_STAT;
    cpu_dout  = 8'hA5;
    cpu_drive = 1'b1;
    #1 check8("data_undriven", data, 8'hA5);
    cpu_drive = 1'b0;
    cpu_read(A_STAT, 1);

    // Overfill, drain in order, clear the sticky drop
    for (int i = 0; i < 9; i++) cpu_write(A_DATA, 8'(8'hA0 + i), 3);
    cpu_read(A_STAT, 1);
    bus.tx_ready = 1'b1;
    wait_drain(40);
    tick();
    bus.tx_ready = 1'b0;
    cpu_read(A_STAT, 1);
    cpu_write(A_CTRL, 8'h01, 1);
    cpu_read(A_STAT, 1);

    // Push into a full FIFO on the same edge as a pop
    for (int i = 0; i < DEPTH; i++) cpu_write(A_DATA, 8'(8'h10 + i), 1);
    bus.tx_ready = 1'b1;
    cpu_write(A_DATA, 8'h55, 1);
    wait_drain(40);
    tick();
    bus.tx_ready = 1'b0;
    cpu_read(A_STAT, 1);

    // RX capture, pop, stale re-read
    rx_send(8'h3C);
    cpu_read(A_STAT, 1);
    cpu_read(A_DATA, 2);
    cpu_read(A_DATA, 1);
    cpu_read(A_RSVD, 1);

    // Flush coincident with a pop
    for (int i = 0; i < 5; i++) cpu_write(A_DATA, 8'(8'hC0 + i), 1);
    bus.tx_ready = 1'b1;
    cpu_write(A_CTRL, 8'h02, 1);
    tick();
    bus.tx_ready = 1'b0;
    cpu_read(A_STAT, 1);

    // Reset with a write strobe held across release
    rx_send(8'h5E);
    cpu_write(A_DATA, 8'h99, 1);
    do_reset_wr_held();
    cpu_read(A_STAT, 1);

    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 11));
      case (op)
        0, 1, 2, 3: cpu_write(A_DATA, 8'($urandom), int'($urandom_range(1, 3)));
        4:          begin bus.tx_ready = 1'($urandom_range(0, 1)); tick(); end
        5, 6:       cpu_read(A_STAT, int'($urandom_range(1, 2)));
        7:          rx_send(8'($urandom));
        8:          cpu_read(A_DATA, int'($urandom_range(1, 2)));
        9:          cpu_write(A_CTRL, 8'($urandom_range(0, 3)), 1);
        10:         cpu_write($urandom_range(0, 1) == 1 ? A_RSVD : A_MISS, 8'($urandom), 1);
        default:    cpu_read(A_RSVD, 1);
      endcase
    end

    bus.tx_ready = 1'b1;
    wait_drain(100);
    tick();
    total++;
    if (rd_exp.size() != 0) begin
      bad++;
      $display("FAIL rd_pending: got %0d reads unchecked expected 0", rd_exp.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
